// File: rtl/noc_pkg.sv
// noc_pkg: shared router constants for port indices, flit types, route and header fields.
package noc_pkg;
  localparam int ROUTE_W = 5;
  localparam int FT_W = 3;
  localparam logic [2:0] PORT_N = 3'd0;
  localparam logic [2:0] PORT_E = 3'd1;
  localparam logic [2:0] PORT_S = 3'd2;
  localparam logic [2:0] PORT_W_IDX = 3'd3;
  localparam logic [2:0] PORT_L = 3'd4;
  localparam logic [2:0] HEAD = 3'b000;
  localparam logic [2:0] BODY = 3'b001;
  localparam logic [2:0] TAIL = 3'b010;
  localparam int ROUTE_PORT_MSB = 4;
  localparam int ROUTE_PORT_LSB = 2;
  localparam int ROUTE_VC_MSB = 1;
  localparam int ROUTE_VC_LSB = 0;
  localparam int HDR_DEST_Y_MSB = 63;
  localparam int HDR_DEST_Y_LSB = 61;
  localparam int HDR_DEST_X_MSB = 60;
  localparam int HDR_DEST_X_LSB = 58;
  localparam int HDR_TYPE_MSB = 57;
  localparam int HDR_TYPE_LSB = 55;
  localparam int HDR_PKT_ID_MSB = 54;
  localparam int HDR_PKT_ID_LSB = 48;
  typedef enum logic {OUT_IDLE, OUT_LOCKED} out_state_e;
  function automatic logic is_payload(input logic [2:0] t);
    return t == BODY || t == TAIL;
  endfunction
endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// rr_arbiter_5: five-way round-robin pick, scanning upward from the slot after ptr_i.
module rr_arbiter_5 (
  input  logic [4:0] req_i,
  input  logic [2:0] ptr_i,
  output logic [4:0] gnt_o,
  output logic [2:0] idx_o
);
  logic [3:0] j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = '0;
    for (int k = 5; k >= 1; k--) begin
      j = {1'b0, ptr_i} + 4'(k);
      j = (j >= 4'd5) ? j - 4'd5 : j;
      if (req_i[j[2:0]]) begin
        gnt_o = 5'd1 << j;
        idx_o = j[2:0];
      end
    end
  end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: wormhole switch allocation; each output is won by a head and held until its tail.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int NPORTS = 5,
  parameter int PORT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*ROUTE_W-1:0] in_route,
  input  logic [NPORTS*FT_W-1:0]   in_flit_type,
  input  logic [NPORTS-1:0]        out_ready,
  output logic [NPORTS-1:0]        grant,
  output logic [NPORTS-1:0]        xbar_valid,
  output logic [NPORTS*PORT_W-1:0] xbar_sel,
  output logic [NPORTS-1:0]        lock_valid,
  output logic                     proto_err
);
  out_state_e state_q [NPORTS];
  out_state_e state_d [NPORTS];
  logic [PORT_W-1:0] owner_q [NPORTS];
  logic [PORT_W-1:0] owner_d [NPORTS];
  logic [PORT_W-1:0] ptr_q [NPORTS];
  logic [PORT_W-1:0] ptr_d [NPORTS];
  logic [PORT_W-1:0] win_idx [NPORTS];
  logic [PORT_W-1:0] port_f [NPORTS];
  logic [FT_W-1:0] type_f [NPORTS];
  logic [NPORTS-1:0] req [NPORTS];
  logic [NPORTS-1:0] cand [NPORTS];
  logic [NPORTS-1:0] win_gnt [NPORTS];
  logic err_q, err_d;
  always_comb begin
    for (int i = 0; i < NPORTS; i++) begin
      port_f[i] = in_route[ROUTE_W*i+ROUTE_PORT_LSB +: PORT_W];
      type_f[i] = in_flit_type[FT_W*i +: FT_W];
    end
  end
  always_comb begin
    for (int o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      cand[o] = '0;
      lock_valid[o] = state_q[o] == OUT_LOCKED;
      for (int i = 0; i < NPORTS; i++) begin
        req[o][i] = in_valid[i] && port_f[i] == PORT_W'(o);
        cand[o][i] = req[o][i] && type_f[i] == HEAD;
      end
    end
  end
  for (genvar o = 0; o < NPORTS; o++) begin : g_arb
    rr_arbiter_5 u_arb (
      .req_i(cand[o]),
      .ptr_i(ptr_q[o]),
      .gnt_o(win_gnt[o]),
      .idx_o(win_idx[o])
    );
  end
  // A tail grant frees the output at the next edge, so the next head can win right after it.
  always_comb begin
    grant = '0;
    xbar_valid = '0;
    xbar_sel = '0;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    for (int o = 0; o < NPORTS; o++) begin
      if (!rst && out_ready[o]) begin
        if (state_q[o] == OUT_IDLE) begin
          if (|cand[o]) begin
            grant = grant | win_gnt[o];
            xbar_valid[o] = 1'b1;
            xbar_sel[PORT_W*o +: PORT_W] = win_idx[o];
            state_d[o] = OUT_LOCKED;
            owner_d[o] = win_idx[o];
            ptr_d[o] = win_idx[o];
          end
        end else if (req[o][owner_q[o]] && is_payload(type_f[owner_q[o]])) begin
          grant[owner_q[o]] = 1'b1;
          xbar_valid[o] = 1'b1;
          xbar_sel[PORT_W*o +: PORT_W] = owner_q[o];
          state_d[o] = (type_f[owner_q[o]] == TAIL) ? OUT_IDLE : OUT_LOCKED;
        end
      end
    end
  end
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NPORTS; i++)
      if (in_valid[i] && (port_f[i] > PORT_W'(NPORTS-1) || type_f[i] > TAIL)) err_d = 1'b1;
    for (int o = 0; o < NPORTS; o++)
      for (int i = 0; i < NPORTS; i++)
        if (req[o][i] && ((state_q[o] == OUT_IDLE && is_payload(type_f[i])) ||
            (state_q[o] == OUT_LOCKED && owner_q[o] == PORT_W'(i) && type_f[i] == HEAD)))
          err_d = 1'b1;
  end
  assign proto_err = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < NPORTS; o++) begin
        state_q[o] <= OUT_IDLE;
        owner_q[o] <= '0;
        ptr_q[o] <= PORT_W'(NPORTS-1);
      end
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed vectors feed a scoreboard queue; a negedge monitor pops and compares.
module tb_switch_allocator;
  import noc_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] in_valid = '0;
  logic [24:0] in_route = '0;
  logic [14:0] in_flit_type = '0;
  logic [4:0] out_ready = '1;
  logic [4:0] grant, xbar_valid, lock_valid;
  logic [14:0] xbar_sel;
  logic proto_err;
  logic [30:0] exp_q [$];
  string nm_q [$];
  int checks = 0;
  int fails = 0;
  localparam logic [4:0] ALL = 5'b11111;
  always #5 clk = ~clk;
  switch_allocator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_route(in_route),
    .in_flit_type(in_flit_type), .out_ready(out_ready), .grant(grant),
    .xbar_valid(xbar_valid), .xbar_sel(xbar_sel), .lock_valid(lock_valid),
    .proto_err(proto_err)
  );
  function automatic logic [24:0] rte(input int i, input logic [2:0] p);
    logic [24:0] x = '0;
    x[5*i+2 +: 3] = p;
    return x;
  endfunction
  function automatic logic [14:0] ty(input int i, input logic [2:0] t);
    logic [14:0] x = '0;
    x[3*i +: 3] = t;
    return x;
  endfunction
  function automatic logic [14:0] sl(input int o, input logic [2:0] idx);
    logic [14:0] x = '0;
    x[3*o +: 3] = idx;
    return x;
  endfunction
  task automatic step(input string nm, input logic r, input logic [4:0] v, input logic [24:0] rt,
                      input logic [14:0] t, input logic [4:0] rdy, input logic [4:0] g,
                      input logic [4:0] xv, input logic [14:0] sel, input logic [4:0] lv,
                      input logic e);
    @(posedge clk);
    #1;
    rst = r;
    in_valid = v;
    in_route = rt;
    in_flit_type = t;
    out_ready = rdy;
    exp_q.push_back({g, xv, sel, lv, e});
    nm_q.push_back(nm);
  endtask
  initial begin
    logic [30:0] e, a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = nm_q.pop_front();
        a = {grant, xbar_valid, xbar_sel, lock_valid, proto_err};
        checks++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s: got grant=%b xv=%b sel=%h lock=%b err=%b, want grant=%b xv=%b sel=%h lock=%b err=%b",
                   nm, a[30:26], a[25:21], a[20:6], a[5:1], a[0], e[30:26], e[25:21], e[20:6], e[5:1], e[0]);
        end
      end
    end
  end
  initial begin
    step("rst_force", 1, 5'b00001, rte(0, PORT_E), '0, ALL, 0, 0, 0, 0, 0);
    step("t1_head", 0, 5'b00001, rte(0, PORT_E), '0, ALL, 5'b00001, 5'b00010, sl(1, 0), 0, 0);
    step("t1_body", 0, 5'b00001, rte(0, PORT_E), ty(0, BODY), ALL, 5'b00001, 5'b00010, sl(1, 0), 5'b00010, 0);
    step("t1_tail", 0, 5'b00001, rte(0, PORT_E), ty(0, TAIL), ALL, 5'b00001, 5'b00010, sl(1, 0), 5'b00010, 0);
    step("t1_idle", 0, 0, '0, '0, ALL, 0, 0, 0, 0, 0);
    step("t2_w_wins", 0, 5'b11000, rte(3, PORT_L) | rte(4, PORT_L), '0, ALL, 5'b01000, 5'b10000, sl(4, 3), 0, 0);
    step("t2_w_tail", 0, 5'b11000, rte(3, PORT_L) | rte(4, PORT_L), ty(3, TAIL), ALL, 5'b01000, 5'b10000, sl(4, 3), 5'b10000, 0);
    step("t2_l_wins", 0, 5'b11000, rte(3, PORT_L) | rte(4, PORT_L), '0, ALL, 5'b10000, 5'b10000, sl(4, 4), 0, 0);
    step("t2_l_tail", 0, 5'b10000, rte(4, PORT_L), ty(4, TAIL), ALL, 5'b10000, 5'b10000, sl(4, 4), 5'b10000, 0);
    step("t2_idle", 0, 0, '0, '0, ALL, 0, 0, 0, 0, 0);
    step("t3_n_head", 0, 5'b00001, rte(0, PORT_E), '0, ALL, 5'b00001, 5'b00010, sl(1, 0), 0, 0);
    step("t3_body1", 0, 5'b00101, rte(0, PORT_E) | rte(2, PORT_E), ty(0, BODY), ALL, 5'b00001, 5'b00010, sl(1, 0), 5'b00010, 0);
    step("t3_body2", 0, 5'b00101, rte(0, PORT_E) | rte(2, PORT_E), ty(0, BODY), ALL, 5'b00001, 5'b00010, sl(1, 0), 5'b00010, 0);
    step("t3_tail", 0, 5'b00101, rte(0, PORT_E) | rte(2, PORT_E), ty(0, TAIL), ALL, 5'b00001, 5'b00010, sl(1, 0), 5'b00010, 0);
    step("t3_s_wins", 0, 5'b00100, rte(2, PORT_E), '0, ALL, 5'b00100, 5'b00010, sl(1, 2), 0, 0);
    step("t3_s_tail", 0, 5'b00100, rte(2, PORT_E), ty(2, TAIL), ALL, 5'b00100, 5'b00010, sl(1, 2), 5'b00010, 0);
    step("t4_head", 0, 5'b00001, rte(0, PORT_E), '0, ALL, 5'b00001, 5'b00010, sl(1, 0), 0, 0);
    step("t4_stall1", 0, 5'b00001, rte(0, PORT_E), ty(0, BODY), 5'b11101, 0, 0, 0, 5'b00010, 0);
    step("t4_stall2", 0, 5'b00001, rte(0, PORT_E), ty(0, BODY), 5'b11101, 0, 0, 0, 5'b00010, 0);
    step("t4_resume", 0, 5'b00001, rte(0, PORT_E), ty(0, BODY), ALL, 5'b00001, 5'b00010, sl(1, 0), 5'b00010, 0);
    step("t5_rst", 1, 5'b00001, rte(0, PORT_E), ty(0, BODY), ALL, 0, 0, 0, 0, 0);
    step("t5_s_head", 0, 5'b00101, rte(0, PORT_E) | rte(2, PORT_E), ty(0, BODY), ALL, 5'b00100, 5'b00010, sl(1, 2), 0, 0);
    step("t5_s_tail", 0, 5'b00100, rte(2, PORT_E), ty(2, TAIL), ALL, 5'b00100, 5'b00010, sl(1, 2), 5'b00010, 1);
    step("t5_idle", 0, 0, '0, '0, ALL, 0, 0, 0, 0, 1);
    step("t6_rst", 1, 0, '0, '0, ALL, 0, 0, 0, 0, 0);
    step("t6_head", 0, 5'b00001, rte(0, PORT_E), '0, ALL, 5'b00001, 5'b00010, sl(1, 0), 0, 0);
    step("t6_dup_head", 0, 5'b00001, rte(0, PORT_E), '0, ALL, 0, 0, 0, 5'b00010, 0);
    step("t6_tail", 0, 5'b00001, rte(0, PORT_E), ty(0, TAIL), ALL, 5'b00001, 5'b00010, sl(1, 0), 5'b00010, 1);
    step("t6_sticky", 0, 0, '0, '0, ALL, 0, 0, 0, 0, 1);
    step("t6_rst2", 1, 0, '0, '0, ALL, 0, 0, 0, 0, 0);
    step("t6_bad_port", 0, 5'b00001, rte(0, 3'b101), '0, ALL, 0, 0, 0, 0, 0);
    step("t6_bad_port_err", 0, 0, '0, '0, ALL, 0, 0, 0, 0, 1);
    step("t6_rst3", 1, 0, '0, '0, ALL, 0, 0, 0, 0, 0);
    step("t6_bad_type", 0, 5'b00100, rte(2, PORT_E), ty(2, 3'b011), ALL, 0, 0, 0, 0, 0);
    step("t6_bad_type_err", 0, 0, '0, '0, ALL, 0, 0, 0, 0, 1);
    step("conc_rst", 1, 0, '0, '0, ALL, 0, 0, 0, 0, 0);
    step("conc_grant", 0, 5'b00111, rte(0, PORT_E) | rte(1, PORT_S) | rte(2, PORT_E), '0, ALL, 5'b00011, 5'b00110, sl(1, 0) | sl(2, 1), 0, 0);
    step("conc_lock", 0, 0, '0, '0, ALL, 0, 0, 0, 5'b00110, 0);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
